// File: rtl/rv32e_prog_loader.sv
// rv32e_prog_loader: byte-stream program loader for a small RV32E core.
// Receives a little-endian word count followed by little-endian 32-bit words,
// writes them into a word-addressed program memory and holds the CPU in reset
// until the whole program has arrived. The CPU fetches through a
// zero-latency combinational read port.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte and an ERROR state for a mismatched checksum.
module rv32e_prog_loader #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic [31:0] prog_addr,
  output logic [31:0] prog_data,
  output logic        cpu_reset_n,
  output logic        load_done,
  output logic        load_error,
  output logic        overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_RUN,
    S_ERROR
  } state_e;

  // State entered once the last stream byte before the checksum is accepted.
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CHK;
`else
  localparam state_e S_END = S_RUN;
`endif

  state_e      state_q;
  logic [15:0] len_q;
  logic [15:0] widx_q;
  logic [1:0]  lane_q;
  logic [23:0] lane_data_q;
  logic        ovf_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  // Memory holds (word XOR NOP): power-up zero content reads back as NOP,
  // so no time-zero initialisation block is needed.
  logic [31:0] mem_q [DEPTH];

  logic        accept;
  logic        word_done;
  logic        last_word;
  logic        in_range;
  logic [31:0] word_d;
  logic [15:0] len_d;

  // Handshake and datapath decode for the current byte.
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA: rx_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:                      rx_ready = 1'b1;
`endif
      default:                    rx_ready = 1'b0;
    endcase
    accept    = rx_valid && rx_ready;
    word_d    = {rx_data, lane_data_q};
    len_d     = {rx_data, len_q[7:0]};
    in_range  = ((32'(widx_q) >> DEPTH_LOG2) == 32'd0);
    last_word = (widx_q == (len_q - 16'd1));
    word_done = accept && (state_q == S_DATA) && (lane_q == 2'd3);
  end

  // Loader FSM: length capture, byte-lane assembly, word counting, overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_LEN_LO;
      len_q       <= '0;
      widx_q      <= '0;
      lane_q      <= '0;
      lane_data_q <= '0;
      ovf_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q <= csum_q ^ rx_data;
`endif
      case (state_q)
        S_LEN_LO: begin
          len_q[7:0] <= rx_data;
          state_q    <= S_LEN_HI;
        end
        S_LEN_HI: begin
          len_q[15:8] <= rx_data;
          state_q     <= (len_d == 16'd0) ? S_END : S_DATA;
        end
        S_DATA: begin
          lane_q <= lane_q + 2'd1;
          case (lane_q)
            2'd0: lane_data_q[7:0]   <= rx_data;
            2'd1: lane_data_q[15:8]  <= rx_data;
            2'd2: lane_data_q[23:16] <= rx_data;
            default: begin
              if (!in_range) ovf_q <= 1'b1;
              widx_q <= widx_q + 16'd1;
              if (last_word) state_q <= S_END;
            end
          endcase
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          state_q <= (rx_data == csum_q) ? S_RUN : S_ERROR;
        end
`endif
        default: state_q <= state_q;
      endcase
    end
  end

  // Program memory write: full word lands on the edge accepting byte 3.
  always_ff @(posedge clk) begin
    if (reset && word_done && in_range) begin
      mem_q[widx_q[DEPTH_LOG2-1:0]] <= word_d ^ NOP;
    end
  end

  // Zero-latency instruction fetch; out-of-range addresses return NOP.
  always_comb begin
    prog_data = NOP;
    if ((prog_addr >> DEPTH_LOG2) == 32'd0) begin
      prog_data = mem_q[prog_addr[DEPTH_LOG2-1:0]] ^ NOP;
    end
  end

  assign cpu_reset_n = (state_q == S_RUN);
  assign load_done   = (state_q == S_RUN);
  assign overflow    = ovf_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign load_error  = (state_q == S_ERROR);
`else
  assign load_error  = 1'b0;
`endif

endmodule
